// File: rtl/control_unit_if.sv
// Control-unit interface: IR and branch condition come from the datapath,
// and the strobes, ALU function and status go back to it.
interface control_unit_if;
  logic [31:0] IR;
  logic        CON_out;
  logic        PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in;
  logic        OutPort_in, CON_in, IncPC;
  logic        PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out;
  logic        Gra, Grb, Grc, Rin, Rout, BAout;
  logic        Read, Write;
  logic [4:0]  alu_op;
  logic        Run;
  logic        illegal;

  modport master (
    input  IR, CON_out,
    output PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in,
           OutPort_in, CON_in, IncPC,
           PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out,
           Gra, Grb, Grc, Rin, Rout, BAout, Read, Write, alu_op, Run, illegal
  );

  modport slave (
    output IR, CON_out,
    input  PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in,
           OutPort_in, CON_in, IncPC,
           PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out,
           Gra, Grb, Grc, Rin, Rout, BAout, Read, Write, alu_op, Run, illegal
  );
endinterface

// File: rtl/control_unit.sv
// Hardwired Moore sequencer for the Mini SRC datapath: fetch T0..T2, then
// per-opcode T3..T7. RAM steps (fetch T1, ld T6, st T7) are stretched by
// MEM_WAIT extra cycles using a down-counter loaded on entry.
// Optional feature: define CONTROL_UNIT_MUL_DIV_EN to decode mul/div.
//
// state | meaning
// RESET | held by clr; all strobes 0, Run 0
// T0    | PC to MAR, PC+1 into Z
// T1    | RAM read of instruction; PC reloaded in final wait cycle
// T2    | MDR to IR; halt/nop decided here
// T3-T7 | opcode-specific execute steps
// HALT  | stopped; leaves only via clr
module control_unit #(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic           clk,
  input  logic           clr,
  control_unit_if.master bus
);
  localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT);

  localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110, OP_ADDI = 5'b01100, OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110, OP_MUL  = 5'b01111, OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_BR   = 5'b10011, OP_JR   = 5'b10100, OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111, OP_MFHI = 5'b11000, OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010, OP_HALT = 5'b11011;
  localparam logic [4:0] ALU_ADD = 5'b00011;

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] wait_q, wait_d;
  logic [4:0] opcode;
  logic [4:0] alu_sel;
  logic       wait_done;
  logic       unused_ir;

  assign opcode    = bus.IR[31:27];
  assign unused_ir = ^bus.IR[26:0];
  assign wait_done = (wait_q == 4'd0);

  // ALU function implied by the opcode; only driven out in computing steps
  always_comb begin
    alu_sel = ALU_ADD;
    case (opcode)
      OP_SUB:          alu_sel = 5'b00100;
      OP_AND, OP_ANDI: alu_sel = 5'b00101;
      OP_OR,  OP_ORI:  alu_sel = 5'b00110;
      OP_MUL:          alu_sel = 5'b01111;
      OP_DIV:          alu_sel = 5'b10000;
      default:         alu_sel = ALU_ADD;
    endcase
  end

  // State and wait-counter registers
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_RESET;
      wait_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Next state, wait counter and strobe decode
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    bus.PC_in = 1'b0; bus.IR_in = 1'b0; bus.Y_in = 1'b0; bus.Z_in = 1'b0;
    bus.HI_in = 1'b0; bus.LO_in = 1'b0; bus.MAR_in = 1'b0; bus.MDR_in = 1'b0;
    bus.OutPort_in = 1'b0; bus.CON_in = 1'b0; bus.IncPC = 1'b0;
    bus.PC_out = 1'b0; bus.Zhigh_out = 1'b0; bus.Zlow_out = 1'b0; bus.HI_out = 1'b0;
    bus.LO_out = 1'b0; bus.MDR_out = 1'b0; bus.InPort_out = 1'b0; bus.C_out = 1'b0;
    bus.Gra = 1'b0; bus.Grb = 1'b0; bus.Grc = 1'b0; bus.Rin = 1'b0; bus.Rout = 1'b0;
    bus.BAout = 1'b0; bus.Read = 1'b0; bus.Write = 1'b0;
    bus.alu_op = 5'b00000;
    bus.illegal = 1'b0;
    bus.Run = (state_q != S_RESET) && (state_q != S_HALT);

    case (state_q)
      S_RESET: state_d = S_T0;
      S_T0: begin
        bus.PC_out = 1'b1; bus.MAR_in = 1'b1; bus.IncPC = 1'b1; bus.Z_in = 1'b1;
        state_d = S_T1;
        wait_d  = WAIT_LOAD;
      end
      S_T1: begin
        bus.Zlow_out = 1'b1; bus.Read = 1'b1; bus.MDR_in = 1'b1;
        bus.PC_in = wait_done;
        if (wait_done) state_d = S_T2;
        else           wait_d  = wait_q - 4'd1;
      end
      S_T2: begin
        bus.MDR_out = 1'b1; bus.IR_in = 1'b1;
        if (opcode == OP_HALT)     state_d = S_HALT;
        else if (opcode == OP_NOP) state_d = S_T0;
        else                       state_d = S_T3;
      end
      S_T3: begin
        state_d = S_T0;
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI: begin
            bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Y_in = 1'b1; state_d = S_T4;
          end
          OP_LDI, OP_LD, OP_ST: begin
            bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Y_in = 1'b1; state_d = S_T4;
          end
          OP_BR: begin
            bus.Gra = 1'b1; bus.Rout = 1'b1; bus.CON_in = 1'b1; state_d = S_T4;
          end
          OP_JR:   begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PC_in = 1'b1; end
          OP_IN:   begin bus.InPort_out = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
          OP_OUT:  begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.OutPort_in = 1'b1; end
          OP_MFHI: begin bus.HI_out = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
          OP_MFLO: begin bus.LO_out = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
`ifdef CONTROL_UNIT_MUL_DIV_EN
          OP_MUL, OP_DIV: begin
            bus.Gra = 1'b1; bus.Rout = 1'b1; bus.Y_in = 1'b1; state_d = S_T4;
          end
`endif
          default: bus.illegal = 1'b1;
        endcase
      end
      S_T4: begin
        state_d = S_T5;
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            bus.Grc = 1'b1; bus.Rout = 1'b1; bus.alu_op = alu_sel; bus.Z_in = 1'b1;
          end
          OP_ADDI, OP_ANDI, OP_ORI, OP_LDI, OP_LD, OP_ST: begin
            bus.C_out = 1'b1; bus.alu_op = alu_sel; bus.Z_in = 1'b1;
          end
          OP_BR: begin bus.PC_out = 1'b1; bus.Y_in = 1'b1; end
`ifdef CONTROL_UNIT_MUL_DIV_EN
          OP_MUL, OP_DIV: begin
            bus.Grb = 1'b1; bus.Rout = 1'b1; bus.alu_op = alu_sel; bus.Z_in = 1'b1;
          end
`endif
          default: state_d = S_T0;
        endcase
      end
      S_T5: begin
        state_d = S_T0;
        case (opcode)
          OP_LD, OP_ST: begin
            bus.Zlow_out = 1'b1; bus.MAR_in = 1'b1; state_d = S_T6;
            if (opcode == OP_LD) wait_d = WAIT_LOAD;
          end
          OP_BR: begin
            bus.C_out = 1'b1; bus.alu_op = ALU_ADD; bus.Z_in = 1'b1; state_d = S_T6;
          end
`ifdef CONTROL_UNIT_MUL_DIV_EN
          OP_MUL, OP_DIV: begin bus.Zlow_out = 1'b1; bus.LO_in = 1'b1; state_d = S_T6; end
`endif
          default: begin bus.Zlow_out = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
        endcase
      end
      S_T6: begin
        state_d = S_T0;
        case (opcode)
          OP_LD: begin
            bus.Read = 1'b1; bus.MDR_in = 1'b1;
            if (wait_done) state_d = S_T7;
            else begin state_d = S_T6; wait_d = wait_q - 4'd1; end
          end
          OP_ST: begin
            bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDR_in = 1'b1;
            state_d = S_T7;
            wait_d  = WAIT_LOAD;
          end
          OP_BR: begin bus.Zlow_out = 1'b1; bus.PC_in = bus.CON_out; end
`ifdef CONTROL_UNIT_MUL_DIV_EN
          OP_MUL, OP_DIV: begin bus.Zhigh_out = 1'b1; bus.HI_in = 1'b1; end
`endif
          default: state_d = S_T0;
        endcase
      end
      S_T7: begin
        state_d = S_T0;
        if (opcode == OP_LD) begin
          bus.MDR_out = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
        end else if (opcode == OP_ST) begin
          bus.Write = 1'b1;
          if (!wait_done) begin state_d = S_T7; wait_d = wait_q - 4'd1; end
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
  end
endmodule
